inst_issue_unit: RTL
====================

Name: inst_issue_unit

Overview:
- Sequencer in front of CONTROL_UNIT. Accepts host instructions over a valid/ready port and buffers them in a FIFO.
- Issues each instruction on the CU instruction bus and holds it for its opcode-specific cycle count; drives IDLE_INST when nothing is pending.
- Replaces testbench-style hand-timed instruction driving with a hardware scheduler; sits between the host/AXI shim and CONTROL_UNIT.

Parameters:
- INST_BITS, 152, instruction width: opcode[151:144], addra[143:136], addrb[135:128], operand[127:0].
- FIFO_DEPTH, 16, instruction buffer entries (power of 2, ≥2).
- IDLE_CYCLE, 1, hold cycles for IDLE_INST.
- WRITE_DATA_CYCLE, 1, hold cycles for WRITE_DATA_INST.
- WRITE_WEIGHT_CYCLE, 1, hold cycles for WRITE_WEIGHT_INST.
- LOAD_DATA_CYCLE, 2, hold cycles for LOAD_DATA_INST.
- LOAD_WEIGHT_CYCLE, 2, hold cycles for LOAD_WEIGHT_INST.
- MAT_MUL_CYCLE, 18, hold cycles for MAT_MUL_INST and MAT_MUL_ACC_INST.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_inst  in  INST_BITS  host instruction.
- in_valid  in  1  host instruction valid.
- in_ready  out  1  unit accepts; a transfer happens when in_valid & in_ready at a rising edge.
- pause  in  1  complete the current instruction, then do not issue new ones.
- flush  in  1  synchronous: empty the FIFO and abort the current instruction.
- instruction  out  INST_BITS  to CONTROL_UNIT.instruction, registered.
- issue  out  1  one-cycle pulse, high in the first cycle of each issued instruction.
- busy  out  1  FIFO non-empty or state==HOLD.
- illegal  out  1  sticky: an undefined opcode was popped; cleared only by reset.
- retired  out  16  count of completed instructions (excluding auto-idle), wraps 0xFFFF->0.

Behaviour:
- Reset (async): instruction=0 (IDLE_INST, all fields 0), issue=0, busy=0, illegal=0, retired=0, FIFO empty, state=EMPTY, in_ready=1 after release.
- in_ready = !full, from the registered occupancy count. No combinational path from in_valid to in_ready.
- States:
  - EMPTY: drive IDLE_INST.
  - HOLD: drive the popped instruction; down-counter cnt loaded with its cycle count.
- EMPTY->HOLD: at an edge where the FIFO is non-empty and pause=0. Pop the head, register it onto instruction, set cnt=CYCLE(opcode), issue=1 for that cycle.
- HOLD, cnt>1: decrement cnt; instruction stable.
- HOLD, cnt==1, edge: retired+1.
  - If the FIFO is non-empty and pause=0, pop the next instruction back-to-back (no bubble) and stay in HOLD.
  - Otherwise go to EMPTY; instruction=0.
- Latency: an instruction accepted at edge k into an empty, idle unit appears on instruction after edge k+1 (no FIFO bypass).
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Undefined opcode (not 0..6): issued as all-zero IDLE for 1 cycle, illegal set, not counted in retired, issue still pulses.
- flush=1 at an edge: FIFO emptied, state=EMPTY, instruction=0, cnt=0, no retire. A push in the same cycle is dropped. flush has priority over pause and pop.
- pause only blocks a new pop; the current HOLD always runs to completion.
- A cycle count of 0 is illegal as a parameter and is treated as 1.

Decomposition:
- Shared ISA package/header, also used by CONTROL_UNIT and the benches:
  - Opcode encodings: IDLE_INST=0, WRITE_DATA_INST=1, WRITE_WEIGHT_INST=2, LOAD_DATA_INST=3, LOAD_WEIGHT_INST=4, MAT_MUL_INST=5, MAT_MUL_ACC_INST=6.
  - Field FROM/TO bit indices; INST_BITS/OPCODE_BITS/ADDRA_BITS/OPERAND_BITS.
  - Default *_CYCLE constants.
- One sub-module: inst_fifo, a synchronous FIFO with full/empty, a count, and a synchronous clear used by flush.
- Opcode->cycle lookup and the FSM stay in the top module.

Test Plan:
- Reset then idle: no pushes for 10 cycles -> instruction==0, issue==0, busy==0, in_ready==1.
- Single LOAD_DATA (addrb=3) pushed at cycle 0 -> appears at cycle 2, held exactly 2 cycles, issue pulses once, retired=1, then instruction==0.
- Back-to-back: push MAT_MUL, MAT_MUL_ACC, LOAD_WEIGHT -> held 18, 18, 2 cycles with no idle gap; retired=3 at the end.
- Full: 17 pushes with no issue (pause=1) -> in_ready low after 16; the 17th is held by the host; releasing pause drains all 16 in order, matching addra values 0..15.
- Flush at cycle 5 of an 18-cycle MAT_MUL with 4 queued -> next cycle instruction==0, busy==0, retired unchanged, nothing else issued.
- Opcode 0x7F pushed -> 1-cycle zero instruction, illegal==1 sticky, retired unchanged; assert reset_n mid-hold -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/inst_issue_unit_pkg.sv
// Shared ISA definitions for the instruction issue path and CONTROL_UNIT:
// field layout, opcode encodings and default per-opcode hold times.
package inst_issue_unit_pkg;

    localparam int INST_BITS    = 152;
    localparam int OPCODE_BITS  = 8;
    localparam int ADDRA_BITS   = 8;
    localparam int ADDRB_BITS   = 8;
    localparam int OPERAND_BITS = 128;

    localparam int OPCODE_FROM  = 151;
    localparam int OPCODE_TO    = 144;
    localparam int ADDRA_FROM   = 143;
    localparam int ADDRA_TO     = 136;
    localparam int ADDRB_FROM   = 135;
    localparam int ADDRB_TO     = 128;
    localparam int OPERAND_FROM = 127;
    localparam int OPERAND_TO   = 0;

    typedef enum logic [OPCODE_BITS-1:0] {
        IDLE_INST         = 8'd0,
        WRITE_DATA_INST   = 8'd1,
        WRITE_WEIGHT_INST = 8'd2,
        LOAD_DATA_INST    = 8'd3,
        LOAD_WEIGHT_INST  = 8'd4,
        MAT_MUL_INST      = 8'd5,
        MAT_MUL_ACC_INST  = 8'd6
    } opcode_e;

    localparam int DEF_IDLE_CYCLE         = 1;
    localparam int DEF_WRITE_DATA_CYCLE   = 1;
    localparam int DEF_WRITE_WEIGHT_CYCLE = 1;
    localparam int DEF_LOAD_DATA_CYCLE    = 2;
    localparam int DEF_LOAD_WEIGHT_CYCLE  = 2;
    localparam int DEF_MAT_MUL_CYCLE      = 18;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } issue_state_e;

    function automatic logic is_defined(input logic [OPCODE_BITS-1:0] op);
        return op <= MAT_MUL_ACC_INST;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction FIFO with occupancy count and a synchronous clear.
module inst_fifo #(
    parameter int WIDTH = 152,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_issue_unit.sv
// Buffers host instructions and presents each one to CONTROL_UNIT for its
// opcode-specific number of cycles, driving IDLE_INST when nothing is pending.
module inst_issue_unit
    import inst_issue_unit_pkg::*;
#(
    parameter int FIFO_DEPTH         = 16,
    parameter int IDLE_CYCLE         = DEF_IDLE_CYCLE,
    parameter int WRITE_DATA_CYCLE   = DEF_WRITE_DATA_CYCLE,
    parameter int WRITE_WEIGHT_CYCLE = DEF_WRITE_WEIGHT_CYCLE,
    parameter int LOAD_DATA_CYCLE    = DEF_LOAD_DATA_CYCLE,
    parameter int LOAD_WEIGHT_CYCLE  = DEF_LOAD_WEIGHT_CYCLE,
    parameter int MAT_MUL_CYCLE      = DEF_MAT_MUL_CYCLE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INST_BITS-1:0] in_inst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 pause,
    input  logic                 flush,
    output logic [INST_BITS-1:0] instruction,
    output logic                 issue,
    output logic                 busy,
    output logic                 illegal,
    output logic [15:0]          retired,
    output issue_state_e         state
);

    logic [INST_BITS-1:0]        head;
    logic                        full;
    logic                        empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic [15:0]                 cnt;
    logic                        cur_illegal;
    logic                        at_end;
    logic                        pop_go;
    logic [OPCODE_BITS-1:0]      head_op;

    // A zero hold time would never retire, so it is promoted to one cycle.
    function automatic logic [15:0] clamp(input int c);
        return (c < 1) ? 16'd1 : 16'(c);
    endfunction

    function automatic logic [15:0] cycle_of(input logic [OPCODE_BITS-1:0] op);
        case (op)
            IDLE_INST:         return clamp(IDLE_CYCLE);
            WRITE_DATA_INST:   return clamp(WRITE_DATA_CYCLE);
            WRITE_WEIGHT_INST: return clamp(WRITE_WEIGHT_CYCLE);
            LOAD_DATA_INST:    return clamp(LOAD_DATA_CYCLE);
            LOAD_WEIGHT_INST:  return clamp(LOAD_WEIGHT_CYCLE);
            MAT_MUL_INST,
            MAT_MUL_ACC_INST:  return clamp(MAT_MUL_CYCLE);
            default:           return 16'd1;
        endcase
    endfunction

    assign head_op  = head[OPCODE_FROM:OPCODE_TO];
    assign in_ready = !full;
    assign at_end   = (state == ST_HOLD) && (cnt == 16'd1);
    assign pop_go   = !empty && !pause && ((state == ST_EMPTY) || at_end);
    assign busy     = !empty || (state == ST_HOLD);

    inst_fifo #(
        .WIDTH (INST_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (in_valid),
        .push_data (in_inst),
        .pop       (pop_go),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Valid/ready: a host word transfers on any rising edge where in_valid and
    // in_ready are both high; in_ready comes only from registered occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_EMPTY;
            instruction <= '0;
            cnt         <= '0;
            issue       <= 1'b0;
            illegal     <= 1'b0;
            cur_illegal <= 1'b0;
            retired     <= '0;
        end else if (flush) begin
            state       <= ST_EMPTY;
            instruction <= '0;
            cnt         <= '0;
            issue       <= 1'b0;
            cur_illegal <= 1'b0;
        end else begin
            issue <= 1'b0;
            if (at_end && !cur_illegal) begin
                retired <= retired + 16'd1;
            end
            if (pop_go) begin
                state       <= ST_HOLD;
                issue       <= 1'b1;
                cur_illegal <= !is_defined(head_op);
                if (is_defined(head_op)) begin
                    instruction <= head;
                    cnt         <= cycle_of(head_op);
                end else begin
                    instruction <= '0;
                    cnt         <= 16'd1;
                    illegal     <= 1'b1;
                end
            end else if (state == ST_HOLD) begin
                if (at_end) begin
                    state       <= ST_EMPTY;
                    instruction <= '0;
                    cnt         <= '0;
                    cur_illegal <= 1'b0;
                end else begin
                    cnt <= cnt - 16'd1;
                end
            end
        end
    end

    logic unused_count;
    assign unused_count = ^count;

endmodule
